// File: rtl/adder_sequencer.sv
// Multi-cycle W-bit adder/subtractor that reuses a single 8-bit adder_block,
// processing one byte per cycle from the least-significant byte upward.

module adder_block (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       g,
    output logic       p,
    output logic       c7
);
    logic [7:0] p_bit;
    logic [7:0] g_bit;
    logic [7:0] c;
    logic [8:0] gc;

    assign c[0]  = cin;
    assign gc[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bits
            assign p_bit[gi]  = a[gi] ^ b[gi];
            assign g_bit[gi]  = a[gi] & b[gi];
            assign s[gi]      = p_bit[gi] ^ c[gi];
            // Group generate is the carry chain evaluated with a zero carry-in.
            assign gc[gi + 1] = g_bit[gi] | (p_bit[gi] & gc[gi]);
        end
        for (gi = 0; gi < 7; gi++) begin : g_carry
            assign c[gi + 1] = g_bit[gi] | (p_bit[gi] & c[gi]);
        end
    endgenerate

    assign g  = gc[8];
    assign p  = &p_bit;
    assign c7 = c[7];
endmodule

module adder_sequencer #(
    parameter int SLICES = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                sub,
    input  logic [8*SLICES-1:0] a,
    input  logic [8*SLICES-1:0] b,
    output logic [8*SLICES-1:0] result,
    output logic                cout,
    output logic                ovf,
    output logic                busy,
    output logic                done
);
    localparam int W     = 8 * SLICES;
    localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [IDX_W+2:0] bit_base;
    logic [7:0]       slice_s;
    logic             slice_g, slice_p, slice_c7, slice_cout;
    logic             last_slice;

    assign bit_base   = {idx_q, 3'b000};
    assign last_slice = (idx_q == IDX_W'(SLICES - 1));
    assign slice_cout = slice_g | (slice_p & carry_q);

    adder_block u_adder (
        .a   (a_q[bit_base +: 8]),
        .b   (b_q[bit_base +: 8]),
        .cin (carry_q),
        .s   (slice_s),
        .g   (slice_g),
        .p   (slice_p),
        .c7  (slice_c7)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert b here, seed carry with sub.
                    state_d = RUN;
                    idx_d   = '0;
                    a_d     = a;
                    b_d     = b ^ {W{sub}};
                    carry_d = sub;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                result_d[bit_base +: 8] = slice_s;
                carry_d                 = slice_cout;
                if (last_slice) begin
                    state_d = DONE;
                    cout_d  = slice_cout;
                    ovf_d   = slice_c7 ^ slice_cout;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
endmodule

// File: tb/tb_adder_sequencer.sv
// Scoreboard bench for adder_sequencer: expected results are queued at start
// and compared whenever the DUT pulses done.

module tb_adder_sequencer;
    localparam int SLICES = 4;
    localparam int W      = 8 * SLICES;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [W-1:0] result;
    logic         cout, ovf, busy, done;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    adder_sequencer #(.SLICES(SLICES)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
        logic [W-1:0] bm;
        logic [W:0]   sum;
        exp_t         e;
        bm   = ts ? ~tb : tb;
        sum  = {1'b0, ta} + {1'b0, bm} + {{W{1'b0}}, ts};
        e.res = sum[W-1:0];
        e.co  = sum[W];
        e.ov  = (ta[W-1] == bm[W-1]) && (sum[W-1] != ta[W-1]);
        return e;
    endfunction

    // Scoreboard side: every done pulse must match the oldest outstanding op.
    always @(negedge clock) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk_eq("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk_eq("result", 64'(result), 64'(e.res));
                chk_eq("cout", 64'(cout), 64'(e.co));
                chk_eq("ovf", 64'(ovf), 64'(e.ov));
                $display("op done: result=0x%08h cout=%0d ovf=%0d", result, cout, ovf);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                          input bit glitch);
        @(negedge clock);
        a = ta; b = tb; sub = ts; start = 1'b1;
        exp_q.push_back(model(ta, tb, ts));
        @(posedge clock);
        for (int k = 0; k < SLICES; k++) begin
            @(negedge clock);
            if (k == 0) begin
                start = 1'b0;
                a = $urandom; b = $urandom; sub = ~sub;
            end
            chk_eq("busy_run", 64'(busy), 64'd1);
            chk_eq("done_run", 64'(done), 64'd0);
            if (glitch && k == 1) begin
                start = 1'b1; a = 32'h10; b = 32'h20;
            end
            if (glitch && k == 2) start = 1'b0;
            @(posedge clock);
        end
        @(negedge clock);
        chk_eq("done_pulse", 64'(done), 64'd1);
        chk_eq("busy_at_done", 64'(busy), 64'd0);
        @(negedge clock);
        chk_eq("done_one_cycle", 64'(done), 64'd0);
        chk_eq("busy_after", 64'(busy), 64'd0);
    endtask

    initial begin
        int last_cyc;
        bit found;

        repeat (3) @(negedge clock);
        chk_eq("rst_result", 64'(result), 64'd0);
        chk_eq("rst_cout", 64'(cout), 64'd0);
        chk_eq("rst_ovf", 64'(ovf), 64'd0);
        chk_eq("rst_busy", 64'(busy), 64'd0);
        chk_eq("rst_done", 64'(done), 64'd0);
        reset = 1'b0;

        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        run_op(32'h00000005, 32'h00000007, 1'b1, 1'b0);
        run_op(32'h00000001, 32'h00000002, 1'b0, 1'b1);
        run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);

        // Abort in the middle of slice 2: no done, everything cleared.
        @(negedge clock);
        a = 32'hDEADBEEF; b = 32'h01020304; sub = 1'b0; start = 1'b1;
        exp_q.push_back(model(a, b, sub));
        @(posedge clock);
        @(negedge clock); start = 1'b0;
        @(negedge clock);
        @(negedge clock); reset = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clock);
        chk_eq("abort_busy", 64'(busy), 64'd0);
        chk_eq("abort_done", 64'(done), 64'd0);
        chk_eq("abort_result", 64'(result), 64'd0);
        chk_eq("abort_cout", 64'(cout), 64'd0);
        chk_eq("abort_ovf", 64'(ovf), 64'd0);
        reset = 1'b0;
        run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0);

        // Back-to-back: start held high, one op every SLICES+1 cycles.
        @(negedge clock);
        a = 32'h80000000; b = 32'h80000000; sub = 1'b0; start = 1'b1;
        for (int n = 0; n < 3; n++) exp_q.push_back(model(a, b, sub));
        last_cyc = 0;
        for (int n = 0; n < 3; n++) begin
            found = 1'b0;
            for (int t = 0; t < 12 && !found; t++) begin
                @(negedge clock);
                if (done) found = 1'b1;
            end
            chk_eq("b2b_done_seen", 64'(found), 64'd1);
            if (n > 0) chk_eq("b2b_period", 64'(cyc - last_cyc), 64'(SLICES + 1));
            last_cyc = cyc;
            if (n == 2) start = 1'b0;
        end
        repeat (SLICES + 2) @(negedge clock);
        chk_eq("final_idle_busy", 64'(busy), 64'd0);
        chk_eq("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
